adder_tree_pipe: RTL

- Parametrised, fully pipelined unsigned adder tree that reduces 2^LEVELS operands of WIDTH bits to one sum of WIDTH+LEVELS bits.
- Generalises the fixed 3-level, 28-bit tree:
  - configurable operand width and depth
  - one register stage per tree level
  - valid/ready flow control with bubble collapsing
  - asynchronous reset
- Sits between operand producers (e.g. a MAC array) and a sum consumer that may apply backpressure.

---
 rtl/adder_tree_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree: 2**LEVELS operands of WIDTH bits reduced to one WIDTH+LEVELS sum,
// one register stage per level, valid/ready with bubble collapsing. Optional accumulator: ADDER_TREE_ACCUM_EN.
module adder_tree_pipe #(
    parameter int WIDTH  = 28,
    parameter int LEVELS = 3
`ifdef ADDER_TREE_ACCUM_EN
    ,
    parameter int ACC_WIDTH = 40
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(1<<LEVELS)*WIDTH-1:0]   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH+LEVELS-1:0]        out_sum,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef ADDER_TREE_ACCUM_EN
    ,
    input  logic                           acc_clear,
    output logic [ACC_WIDTH-1:0]           acc_sum
`endif
);

    localparam int N     = 1 << LEVELS;
    localparam int OUT_W = WIDTH + LEVELS;

    // Bit offset of stage k inside the flattened pipeline vector; stage i holds N>>i words of WIDTH+i bits.
    function automatic int stage_offset(input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) off += (N >> i) * (WIDTH + i);
        return off;
    endfunction

    localparam int TOTAL_BITS = stage_offset(LEVELS + 1);

    logic [TOTAL_BITS-1:0] pipe_data;
    logic [LEVELS:0]       valid;
    logic [LEVELS:0]       valid_in;
    logic [LEVELS+1:0]     ready;

    assign valid_in = {valid[LEVELS-1:0], in_valid};

    // NOTE: ready ripples from the output back to in_ready in one cycle; this is the only combinational path.
    always_comb begin
        ready             = '0;
        ready[LEVELS+1]   = out_ready;
        for (int k = LEVELS; k >= 0; k--) ready[k] = !valid[k] || ready[k+1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            for (int k = 0; k <= LEVELS; k++)
                if (ready[k]) valid[k] <= valid_in[k];
        end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
        localparam int CNT = N >> k;
        localparam int SW  = WIDTH + k;
        localparam int OFF = stage_offset(k);

        logic [CNT*SW-1:0] d_next;
        logic [CNT*SW-1:0] d_q;

        if (k == 0) begin : g_in
            assign d_next = in_data;
        end else begin : g_add
            localparam int PW   = SW - 1;
            localparam int POFF = stage_offset(k - 1);
            for (genvar j = 0; j < CNT; j++) begin : g_pair
                assign d_next[j*SW +: SW] = {1'b0, pipe_data[POFF + (2*j)*PW +: PW]}
                                          + {1'b0, pipe_data[POFF + (2*j+1)*PW +: PW]};
            end
        end

        // NOTE: data registers are reset so out_sum reads 0 after reset; bubbles skip the load since only valid gives meaning.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                          d_q <= '0;
            else if (ready[k] && valid_in[k]) d_q <= d_next;
        end

        assign pipe_data[OFF +: CNT*SW] = d_q;
    end

    assign in_ready  = ready[0];
    assign out_valid = valid[LEVELS];
    assign out_sum   = pipe_data[stage_offset(LEVELS) +: OUT_W];

`ifdef ADDER_TREE_ACCUM_EN
    // Clear takes priority over a coincident handshake; the sum wraps modulo 2**ACC_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         acc_sum <= '0;
        else if (acc_clear)              acc_sum <= '0;
        else if (out_valid && out_ready) acc_sum <= acc_sum + ACC_WIDTH'(out_sum);
    end
`else
    // Accumulator not built: no acc_clear/acc_sum ports and no accumulation logic.
`endif

endmodule
